// File: rtl/sram_arbiter_pkg.sv
// Shared widths, FSM state codes and port indices for the four-port SRAM arbiter.
package sram_arbiter_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  localparam logic [1:0] PORT_W0 = 2'd0;
  localparam logic [1:0] PORT_W1 = 2'd1;
  localparam logic [1:0] PORT_R0 = 2'd2;
  localparam logic [1:0] PORT_R1 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_W0     = 3'd1,
    ST_W1     = 3'd2,
    ST_R0     = 3'd3,
    ST_R1     = 3'd4,
    ST_RWAIT0 = 3'd5,
    ST_RWAIT1 = 3'd6
  } state_e;

  function automatic state_e issue_state(input logic [1:0] port);
    state_e st;
    case (port)
      PORT_W0: st = ST_W0;
      PORT_W1: st = ST_W1;
      PORT_R0: st = ST_R0;
      default: st = ST_R1;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Client-side request/response ports plus the SRAM controller command/data channel.
interface sram_arbiter_if #(
  parameter int ADDR_W = sram_arbiter_pkg::ADDR_W,
  parameter int DATA_W = sram_arbiter_pkg::DATA_W,
  parameter int MASK_W = sram_arbiter_pkg::MASK_W
);
  logic                             w0_din_ready;
  logic                             w0_din_valid;
  logic [ADDR_W+DATA_W+MASK_W-1:0]  w0_din;
  logic                             w1_din_ready;
  logic                             w1_din_valid;
  logic [ADDR_W+DATA_W+MASK_W-1:0]  w1_din;
  logic                             r0_din_ready;
  logic                             r0_din_valid;
  logic [ADDR_W-1:0]                r0_din;
  logic                             r1_din_ready;
  logic                             r1_din_valid;
  logic [ADDR_W-1:0]                r1_din;
  logic                             r0_dout_ready;
  logic                             r0_dout_valid;
  logic [DATA_W-1:0]                r0_dout;
  logic                             r1_dout_ready;
  logic                             r1_dout_valid;
  logic [DATA_W-1:0]                r1_dout;
  logic [2:0]                       state;
  logic                             sram_addr_valid;
  logic                             sram_ready;
  logic [ADDR_W-1:0]                sram_addr;
  logic [DATA_W-1:0]                sram_data_in;
  logic [MASK_W-1:0]                sram_write_mask;
  logic [DATA_W-1:0]                sram_data_out;
  logic                             sram_data_out_valid;

  modport slave (
    output w0_din_ready, w1_din_ready, r0_din_ready, r1_din_ready,
    input  w0_din_valid, w1_din_valid, r0_din_valid, r1_din_valid,
    input  w0_din, w1_din, r0_din, r1_din,
    input  r0_dout_ready, r1_dout_ready,
    output r0_dout_valid, r1_dout_valid, r0_dout, r1_dout,
    output state, sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
    input  sram_ready, sram_data_out, sram_data_out_valid
  );

  modport master (
    input  w0_din_ready, w1_din_ready, r0_din_ready, r1_din_ready,
    output w0_din_valid, w1_din_valid, r0_din_valid, r1_din_valid,
    output w0_din, w1_din, r0_din, r1_din,
    output r0_dout_ready, r1_dout_ready,
    input  r0_dout_valid, r1_dout_valid, r0_dout, r1_dout,
    input  state, sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
    output sram_ready, sram_data_out, sram_data_out_valid
  );
endinterface

// File: rtl/sram_arbiter_req_buf.sv
// Single-entry request holding register: loads on vld&&rdy, visible next cycle.
// Ready only while empty; the entry stays until the arbiter clears it.
module sram_arbiter_req_buf #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_clr,
  output logic             o_pend,
  output logic [WIDTH-1:0] o_dat
);

  logic             r_pend;
  logic [WIDTH-1:0] r_dat;

  // Load and clear are mutually exclusive: clear only fires while pending, load only while empty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= 1'b0;
      r_dat  <= '0;
    end else if (i_vld && !r_pend) begin
      r_pend <= 1'b1;
      r_dat  <= i_dat;
    end else if (i_clr) begin
      r_pend <= 1'b0;
    end
  end

  assign o_rdy  = !r_pend;
  assign o_pend = r_pend;
  assign o_dat  = r_dat;

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter of two write and two read clients onto one SRAM controller.
// One transaction in flight; grant one cycle after a request lands; commands hold until sram_ready.
module sram_arbiter
  import sram_arbiter_pkg::*;
(
  input  logic          sram_clock,
  input  logic          reset,
  sram_arbiter_if.slave bus
);

  localparam int WDAT_W = ADDR_W + DATA_W + MASK_W;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [1:0]          r_last;
  logic [1:0]          w_last_nxt;
  logic [3:0]          w_pend;
  logic [3:0]          w_clr;
  logic [3:0]          w_elig;
  logic [2:0]          w_pick;
  logic                w_cap0;
  logic                w_cap1;
  logic [WDAT_W-1:0]   w_w0_dat;
  logic [WDAT_W-1:0]   w_w1_dat;
  logic [ADDR_W-1:0]   w_r0_addr;
  logic [ADDR_W-1:0]   w_r1_addr;
  logic                r_r0_dout_vld;
  logic                r_r1_dout_vld;
  logic [DATA_W-1:0]   r_r0_dout;
  logic [DATA_W-1:0]   r_r1_dout;

  sram_arbiter_req_buf #(.WIDTH(WDAT_W)) u_buf_w0 (
    .i_clk(sram_clock), .i_rst(reset), .i_vld(bus.w0_din_valid), .o_rdy(bus.w0_din_ready),
    .i_dat(bus.w0_din), .i_clr(w_clr[PORT_W0]), .o_pend(w_pend[PORT_W0]), .o_dat(w_w0_dat)
  );
  sram_arbiter_req_buf #(.WIDTH(WDAT_W)) u_buf_w1 (
    .i_clk(sram_clock), .i_rst(reset), .i_vld(bus.w1_din_valid), .o_rdy(bus.w1_din_ready),
    .i_dat(bus.w1_din), .i_clr(w_clr[PORT_W1]), .o_pend(w_pend[PORT_W1]), .o_dat(w_w1_dat)
  );
  sram_arbiter_req_buf #(.WIDTH(ADDR_W)) u_buf_r0 (
    .i_clk(sram_clock), .i_rst(reset), .i_vld(bus.r0_din_valid), .o_rdy(bus.r0_din_ready),
    .i_dat(bus.r0_din), .i_clr(w_clr[PORT_R0]), .o_pend(w_pend[PORT_R0]), .o_dat(w_r0_addr)
  );
  sram_arbiter_req_buf #(.WIDTH(ADDR_W)) u_buf_r1 (
    .i_clk(sram_clock), .i_rst(reset), .i_vld(bus.r1_din_valid), .o_rdy(bus.r1_din_ready),
    .i_dat(bus.r1_din), .i_clr(w_clr[PORT_R1]), .o_pend(w_pend[PORT_R1]), .o_dat(w_r1_addr)
  );

  // Returns {found, port}; the port right after 'last' wins, 'last' itself is considered last.
  function automatic logic [2:0] rr_pick(input logic [3:0] elig, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (elig[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // A read port holding unconsumed data may not start another read.
  assign w_elig = {w_pend[PORT_R1] & ~r_r1_dout_vld,
                   w_pend[PORT_R0] & ~r_r0_dout_vld,
                   w_pend[PORT_W1], w_pend[PORT_W0]};
  assign w_pick = rr_pick(w_elig, r_last);

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_last  <= PORT_R1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_clr       = '0;
    w_cap0      = 1'b0;
    w_cap1      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick[2]) begin
          w_last_nxt  = w_pick[1:0];
          w_state_nxt = issue_state(w_pick[1:0]);
        end
      end
      ST_W0: if (bus.sram_ready) begin
        w_clr[PORT_W0] = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      ST_W1: if (bus.sram_ready) begin
        w_clr[PORT_W1] = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      ST_R0: if (bus.sram_ready) w_state_nxt = ST_RWAIT0;
      ST_R1: if (bus.sram_ready) w_state_nxt = ST_RWAIT1;
      ST_RWAIT0: if (bus.sram_data_out_valid) begin
        w_clr[PORT_R0] = 1'b1;
        w_cap0         = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      ST_RWAIT1: if (bus.sram_data_out_valid) begin
        w_clr[PORT_R1] = 1'b1;
        w_cap1         = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Command fields come straight from the granted buffer, which cannot change until it is cleared.
  always_comb begin
    bus.sram_addr_valid = 1'b0;
    bus.sram_addr       = '0;
    bus.sram_data_in    = '0;
    bus.sram_write_mask = '0;
    case (r_state)
      ST_W0: begin
        bus.sram_addr_valid = 1'b1;
        {bus.sram_addr, bus.sram_data_in, bus.sram_write_mask} = w_w0_dat;
      end
      ST_W1: begin
        bus.sram_addr_valid = 1'b1;
        {bus.sram_addr, bus.sram_data_in, bus.sram_write_mask} = w_w1_dat;
      end
      ST_R0: begin
        bus.sram_addr_valid = 1'b1;
        bus.sram_addr       = w_r0_addr;
      end
      ST_R1: begin
        bus.sram_addr_valid = 1'b1;
        bus.sram_addr       = w_r1_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      r_r0_dout_vld <= 1'b0;
      r_r1_dout_vld <= 1'b0;
      r_r0_dout     <= '0;
      r_r1_dout     <= '0;
    end else begin
      if (w_cap0) begin
        r_r0_dout_vld <= 1'b1;
        r_r0_dout     <= bus.sram_data_out;
      end else if (bus.r0_dout_ready) begin
        r_r0_dout_vld <= 1'b0;
      end
      if (w_cap1) begin
        r_r1_dout_vld <= 1'b1;
        r_r1_dout     <= bus.sram_data_out;
      end else if (bus.r1_dout_ready) begin
        r_r1_dout_vld <= 1'b0;
      end
    end
  end

  assign bus.state         = r_state;
  assign bus.r0_dout_valid = r_r0_dout_vld;
  assign bus.r1_dout_valid = r_r1_dout_vld;
  assign bus.r0_dout       = r_r0_dout;
  assign bus.r1_dout       = r_r1_dout;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int WDAT_W = ADDR_W + DATA_W + MASK_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [3:0]          vld;
  logic [WDAT_W-1:0]   wdin [2];
  logic [ADDR_W-1:0]   rdin [2];
  logic [1:0]          dout_rdy;
  logic                s_rdy;
  logic                s_dvld;
  logic [DATA_W-1:0]   s_dout;

  sram_arbiter_if bus ();

  sram_arbiter dut (
    .sram_clock (clk),
    .reset      (rst),
    .bus        (bus)
  );

  assign bus.w0_din_valid        = vld[0];
  assign bus.w1_din_valid        = vld[1];
  assign bus.r0_din_valid        = vld[2];
  assign bus.r1_din_valid        = vld[3];
  assign bus.w0_din              = wdin[0];
  assign bus.w1_din              = wdin[1];
  assign bus.r0_din              = rdin[0];
  assign bus.r1_din              = rdin[1];
  assign bus.r0_dout_ready       = dout_rdy[0];
  assign bus.r1_dout_ready       = dout_rdy[1];
  assign bus.sram_ready          = s_rdy;
  assign bus.sram_data_out       = s_dout;
  assign bus.sram_data_out_valid = s_dvld;

  wire [3:0] rdy  = {bus.r1_din_ready, bus.r0_din_ready, bus.w1_din_ready, bus.w0_din_ready};
  wire [1:0] dvld = {bus.r1_dout_valid, bus.r0_dout_valid};
  wire [WDAT_W-1:0] cmd = {bus.sram_addr, bus.sram_data_in, bus.sram_write_mask};

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    vld = '0; dout_rdy = '0; s_rdy = 1'b0; s_dvld = 1'b0; s_dout = '0;
    wdin[0] = '0; wdin[1] = '0; rdin[0] = '0; rdin[1] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (4) step();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", bus.state); end
    checks++; if (rdy !== 4'hF) begin errors++; $display("FAIL rst_din_ready: got %b expected 1111", rdy); end
    checks++; if (bus.sram_addr_valid !== 1'b0) begin errors++; $display("FAIL rst_addr_valid: got %b expected 0", bus.sram_addr_valid); end
    checks++; if (dvld !== 2'b00) begin errors++; $display("FAIL rst_dout_valid: got %b expected 00", dvld); end
    checks++; if ({bus.r0_dout, bus.r1_dout} !== 64'h0) begin errors++; $display("FAIL rst_dout: got %h %h expected 0", bus.r0_dout, bus.r1_dout); end
    checks++; if (cmd !== '0) begin errors++; $display("FAIL rst_cmd: got %h expected 0", cmd); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    wdin[0] = {18'h00010, 32'hDEADBEEF, 4'hF};
    vld[0]  = 1'b1;
    s_rdy   = 1'b1;
    step(); vld[0] = 1'b0;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL wr_state_e0: got %0d expected 0", bus.state); end
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL wr_ready_e0: got %b expected 0", rdy[0]); end
    step();
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL wr_state_e1: got %0d expected 1", bus.state); end
    checks++; if (bus.sram_addr_valid !== 1'b1) begin errors++; $display("FAIL wr_addr_valid: got %b expected 1", bus.sram_addr_valid); end
    checks++; if (cmd !== {18'h00010, 32'hDEADBEEF, 4'hF}) begin errors++; $display("FAIL wr_cmd: got %h expected 00010/DEADBEEF/F", cmd); end
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL wr_ready_e1: got %b expected 0", rdy[0]); end
    step();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL wr_state_e2: got %0d expected 0", bus.state); end
    checks++; if (bus.sram_addr_valid !== 1'b0) begin errors++; $display("FAIL wr_addr_valid_e2: got %b expected 0", bus.sram_addr_valid); end
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL wr_ready_e2: got %b expected 1", rdy[0]); end
  endtask

  task automatic test_read();
    rdin[1] = 18'h00020;
    vld[3]  = 1'b1;
    s_rdy   = 1'b1;
    step(); vld[3] = 1'b0;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rd_state_e0: got %0d expected 0", bus.state); end
    step();
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL rd_state_e1: got %0d expected 4", bus.state); end
    checks++; if ({bus.sram_addr_valid, cmd} !== {1'b1, 18'h00020, 36'h0}) begin errors++; $display("FAIL rd_cmd: got v=%b %h expected v=1 00020/0/0", bus.sram_addr_valid, cmd); end
    step();
    checks++; if (bus.state !== 3'd6) begin errors++; $display("FAIL rd_state_wait: got %0d expected 6", bus.state); end
    checks++; if (bus.sram_addr_valid !== 1'b0) begin errors++; $display("FAIL rd_wait_addr_valid: got %b expected 0", bus.sram_addr_valid); end
    step();
    s_dvld = 1'b1; s_dout = 32'h12345678;
    step(); s_dvld = 1'b0; s_dout = '0;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL rd_state_done: got %0d expected 0", bus.state); end
    checks++; if ({dvld[1], bus.r1_dout} !== {1'b1, 32'h12345678}) begin errors++; $display("FAIL rd_dout: got v=%b %h expected v=1 12345678", dvld[1], bus.r1_dout); end
    checks++; if (rdy[3] !== 1'b1) begin errors++; $display("FAIL rd_din_ready: got %b expected 1", rdy[3]); end
    step();
    checks++; if (dvld[1] !== 1'b1) begin errors++; $display("FAIL rd_dout_hold: got %b expected 1", dvld[1]); end
    dout_rdy[1] = 1'b1;
    step(); dout_rdy[1] = 1'b0;
    checks++; if (dvld[1] !== 1'b0) begin errors++; $display("FAIL rd_dout_consumed: got %b expected 0", dvld[1]); end
  endtask

  task automatic test_all_four();
    logic [2:0]        exp_st [10] = '{3'd1, 3'd0, 3'd2, 3'd0, 3'd3, 3'd5, 3'd0, 3'd4, 3'd6, 3'd0};
    logic [ADDR_W-1:0] exp_a  [4]  = '{18'h00100, 18'h00200, 18'h00300, 18'h00400};
    logic [MASK_W-1:0] exp_m  [4]  = '{4'h3, 4'hC, 4'h0, 4'h0};
    wdin[0] = {18'h00100, 32'h11111111, 4'h3};
    wdin[1] = {18'h00200, 32'h22222222, 4'hC};
    rdin[0] = 18'h00300;
    rdin[1] = 18'h00400;
    vld = 4'hF; s_rdy = 1'b1; s_dvld = 1'b1; s_dout = 32'hCAFE0001; dout_rdy = 2'b11;
    step(); vld = 4'h0;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL all4_state_load: got %0d expected 0", bus.state); end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (bus.state !== exp_st[i]) begin errors++; $display("FAIL all4_state[%0d]: got %0d expected %0d", i, bus.state, exp_st[i]); end
      if (exp_st[i] >= 3'd1 && exp_st[i] <= 3'd4) begin
        checks++;
        if ({bus.sram_addr, bus.sram_write_mask} !== {exp_a[exp_st[i]-1], exp_m[exp_st[i]-1]}) begin
          errors++; $display("FAIL all4_cmd[%0d]: got %h/%h expected %h/%h", i, bus.sram_addr, bus.sram_write_mask, exp_a[exp_st[i]-1], exp_m[exp_st[i]-1]);
        end
      end
      if (i == 6) begin
        checks++; if ({dvld[0], bus.r0_dout} !== {1'b1, 32'hCAFE0001}) begin errors++; $display("FAIL all4_r0_dout: got v=%b %h expected v=1 CAFE0001", dvld[0], bus.r0_dout); end
      end
    end
    checks++; if ({dvld[1], bus.r1_dout} !== {1'b1, 32'hCAFE0001}) begin errors++; $display("FAIL all4_r1_dout: got v=%b %h expected v=1 CAFE0001", dvld[1], bus.r1_dout); end
    s_dvld = 1'b0; s_dout = '0;
    step(); dout_rdy = 2'b00;
    checks++; if ({bus.state, rdy, dvld} !== {3'd0, 4'hF, 2'b00}) begin errors++; $display("FAIL all4_end: got st=%0d rdy=%b dv=%b expected 0/1111/00", bus.state, rdy, dvld); end
  endtask

  task automatic test_stall();
    logic [WDAT_W-1:0] pay = {18'h2ABCD, 32'h0BADF00D, 4'h5};
    wdin[1] = pay;
    vld[1]  = 1'b1;
    s_rdy   = 1'b0;
    step(); vld[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL stall_state[%0d]: got %0d expected 2", i, bus.state); end
      checks++; if ({bus.sram_addr_valid, cmd} !== {1'b1, pay}) begin errors++; $display("FAIL stall_cmd[%0d]: got v=%b %h expected v=1 %h", i, bus.sram_addr_valid, cmd, pay); end
    end
    s_rdy = 1'b1;
    step(); s_rdy = 1'b0;
    checks++; if ({bus.state, bus.sram_addr_valid, rdy[1]} !== {3'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL stall_done: got st=%0d v=%b rdy=%b expected 0/0/1", bus.state, bus.sram_addr_valid, rdy[1]); end
  endtask

  task automatic test_reset_mid();
    rdin[0] = 18'h00777;
    vld[2]  = 1'b1;
    s_rdy   = 1'b1;
    step(); vld[2] = 1'b0;
    step();
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL rmid_issue: got %0d expected 3", bus.state); end
    step();
    checks++; if (bus.state !== 3'd5) begin errors++; $display("FAIL rmid_wait: got %0d expected 5", bus.state); end
    rst = 1'b1; s_rdy = 1'b0;
    step();
    checks++; if ({bus.state, rdy[2], dvld[0], bus.sram_addr_valid} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL rmid_reset: got st=%0d rdy=%b dv=%b av=%b expected 0/1/0/0", bus.state, rdy[2], dvld[0], bus.sram_addr_valid); end
    rst = 1'b0; s_dvld = 1'b1; s_dout = 32'hFEEDFACE;
    step(); s_dvld = 1'b0; s_dout = '0;
    checks++; if ({bus.state, dvld[0], bus.r0_dout} !== {3'd0, 1'b0, 32'h0}) begin errors++; $display("FAIL rmid_late_data: got st=%0d dv=%b %h expected 0/0/0", bus.state, dvld[0], bus.r0_dout); end
  endtask

  // Reference model: each port holds at most one request; an idle arbiter grants the first
  // eligible port after the last granted one; a backing memory answers reads.
  function automatic int rr_next(input logic [3:0] e, input int last);
    for (int i = 1; i <= 4; i++) if (e[(last + i) % 4]) return (last + i) % 4;
    return -1;
  endfunction

  task automatic test_random();
    localparam int NGEN = 2500;
    localparam int NCYC = 2700;
    logic [DATA_W-1:0] mem [16];
    logic [3:0]        m_pend = '0, m_drv = '0, elig_prev = '0;
    logic [1:0]        m_held = '0;
    logic [ADDR_W-1:0] m_addr [4], d_addr [4];
    logic [DATA_W-1:0] m_data [4], d_data [4], m_exp [2];
    logic [MASK_W-1:0] m_mask [4], d_mask [4];
    logic              m_cmd = 1'b0, m_rd = 1'b0, idle_prev = 1'b1;
    int                m_port = 0, m_last = 3, m_delay = 0;
    logic [DATA_W-1:0] cur_dout;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int p = 0; p < 4; p++) begin
      m_addr[p] = '0; d_addr[p] = '0; m_data[p] = '0; d_data[p] = '0; m_mask[p] = '0; d_mask[p] = '0;
    end
    m_exp[0] = '0; m_exp[1] = '0;
    drive_idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      for (int p = 0; p < 4; p++) begin
        checks++; if (rdy[p] !== !m_pend[p]) begin errors++; $display("FAIL rand_din_ready[%0d] cyc %0d: got %b expected %b", p, cyc, rdy[p], !m_pend[p]); end
      end
      for (int r = 0; r < 2; r++) begin
        cur_dout = (r == 0) ? bus.r0_dout : bus.r1_dout;
        checks++; if (dvld[r] !== m_held[r]) begin errors++; $display("FAIL rand_dout_valid[%0d] cyc %0d: got %b expected %b", r, cyc, dvld[r], m_held[r]); end
        if (m_held[r]) begin
          checks++; if (cur_dout !== m_exp[r]) begin errors++; $display("FAIL rand_dout[%0d] cyc %0d: got %h expected %h", r, cyc, cur_dout, m_exp[r]); end
        end
      end
      if (idle_prev && elig_prev != 4'h0) begin
        m_cmd  = 1'b1;
        m_port = rr_next(elig_prev, m_last);
        m_last = m_port;
      end
      checks++; if (bus.sram_addr_valid !== m_cmd) begin errors++; $display("FAIL rand_addr_valid cyc %0d: got %b expected %b", cyc, bus.sram_addr_valid, m_cmd); end
      if (m_cmd) begin
        checks++;
        if (cmd !== {m_addr[m_port], m_data[m_port], m_mask[m_port]}) begin
          errors++; $display("FAIL rand_cmd cyc %0d port %0d: got %h expected %h", cyc, m_port, cmd, {m_addr[m_port], m_data[m_port], m_mask[m_port]});
        end
      end
      idle_prev = !m_cmd && !m_rd;
      for (int p = 0; p < 4; p++) elig_prev[p] = m_pend[p] && !(p >= 2 && m_held[p-2]);

      for (int p = 0; p < 4; p++) begin
        if (!m_drv[p] && cyc < NGEN && $urandom_range(0, 2) == 0) begin
          m_drv[p]  = 1'b1;
          d_addr[p] = ADDR_W'($urandom_range(0, 15));
          d_data[p] = (p < 2) ? DATA_W'($urandom) : '0;
          d_mask[p] = (p < 2) ? MASK_W'($urandom_range(1, 15)) : '0;
          if (p < 2) wdin[p] = {d_addr[p], d_data[p], d_mask[p]};
          else       rdin[p-2] = d_addr[p];
        end
        vld[p] = m_drv[p];
      end
      s_rdy    = (cyc >= NGEN) || ($urandom_range(0, 3) != 0);
      dout_rdy = (cyc >= NGEN) ? 2'b11 : 2'($urandom_range(0, 3));
      if (m_rd && m_delay == 0) begin
        s_dvld = 1'b1; s_dout = mem[m_addr[m_port][3:0]];
      end else begin
        if (m_rd) m_delay--;
        s_dvld = !m_rd && ($urandom_range(0, 7) == 0);
        s_dout = DATA_W'($urandom);
      end

      for (int p = 0; p < 4; p++) begin
        if (m_drv[p] && rdy[p]) begin
          m_pend[p] = 1'b1; m_drv[p] = 1'b0;
          m_addr[p] = d_addr[p]; m_data[p] = d_data[p]; m_mask[p] = d_mask[p];
        end
      end
      for (int r = 0; r < 2; r++) if (m_held[r] && dout_rdy[r]) m_held[r] = 1'b0;
      if (m_cmd && s_rdy) begin
        m_cmd = 1'b0;
        if (m_port < 2) begin
          for (int b = 0; b < MASK_W; b++)
            if (m_mask[m_port][b]) mem[m_addr[m_port][3:0]][8*b +: 8] = m_data[m_port][8*b +: 8];
          m_pend[m_port] = 1'b0;
        end else begin
          m_rd = 1'b1; m_delay = $urandom_range(0, 3);
        end
      end else if (m_rd && s_dvld) begin
        m_rd = 1'b0;
        m_pend[m_port] = 1'b0;
        m_held[m_port-2] = 1'b1;
        m_exp[m_port-2] = s_dout;
      end
      step();
    end
    checks++; if ({m_pend, m_drv, m_cmd, m_rd} !== 10'h0) begin errors++; $display("FAIL rand_drain: got pend=%b drv=%b cmd=%b rd=%b expected all 0", m_pend, m_drv, m_cmd, m_rd); end
    checks++; if (rdy !== 4'hF) begin errors++; $display("FAIL rand_drain_ready: got %b expected 1111", rdy); end
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single_write();
    test_read();
    test_all_four();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
